trig_pattern_decoder: RTL and testbench
=======================================

# trig_pattern_decoder

Decodes the serial trigger line produced by the pre-trigger generator into discrete trigger commands. Each 4-bit pulse pattern on the line is mapped to one command code:
- PRE_L1
- L1
- L1_PS
- ALIGN
- RESET

The block sits directly downstream of the generator, in the same clock domain, and feeds command strobes, per-frame status and error counters to the readout/control logic.

## Interface
- No parameters; all widths are fixed.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  decoder enable; low forces abort to WAIT_LOW.
- trig_in  in  1  serial trigger line, synchronous to clk, idle low.
- clr_cnt  in  1  synchronous clear of cmd_count and err_count.
- cmd_valid  out  1  one-cycle strobe: valid command decoded.
- cmd_code  out  3  decoded code: 0 PRE_L1, 1 L1, 2 L1_PS, 3 ALIGN, 4 RESET. Holds its value between strobes.
- err  out  1  one-cycle strobe: malformed frame.
- err_type  out  2  1 unknown pattern, 2 framing (guard bit high). Holds its value between strobes.
- raw_pattern  out  4  last captured 4 bits, first bit in bit 3.
- cmd_count  out  16  saturating count of cmd_valid strobes.
- err_count  out  16  saturating count of err strobes.

## Operation
- Frame format: 4 pattern bits on consecutive cycles (first bit always 1), then at least one guard cycle at 0.
- Pattern map, first bit leftmost:
  - 1110 -> 0
  - 1000 -> 1
  - 1100 -> 2
  - 1010 -> 3
  - 1111 -> 4
  - any other first-bit-1 pattern -> err_type 1.
- FSM states:
  - WAIT_LOW: stay until trig_in=0 sampled, then go to IDLE.
  - IDLE: trig_in=1 sampled -> shift reg = 1, bit counter = 1, go to CAPTURE.
  - CAPTURE: shift in trig_in each cycle. When bit counter reaches 4, latch raw_pattern and go to GUARD.
  - GUARD: sample the guard bit.
    - trig_in=0: decode the pattern and emit cmd_valid or err (type 1), then go to IDLE.
    - trig_in=1: emit err (type 2) with no command decode, then go to WAIT_LOW.
- en=0 in any state: next state is WAIT_LOW, the frame in progress is discarded, no strobe is issued. While en=0 the counters still respond to clr_cnt.
- Counters:
  - Increment on their strobe and saturate at 0xFFFF with no wrap.
  - clr_cnt has priority over an increment in the same cycle; the result is 0.

## Timing
- First pattern bit sampled at edge k. Pattern bits are sampled at edges k..k+3, the guard bit at edge k+4.
- cmd_valid/err, cmd_code/err_type and the counter update are all registered at edge k+4, visible for the cycle k+4..k+5.
- raw_pattern updates at edge k+3.
- Back-to-back frames: a new first bit may be sampled at edge k+5, i.e. the guard cycle is followed immediately by the next frame. Minimum frame spacing is 5 cycles.
- Reset values:
  - state WAIT_LOW.
  - cmd_valid=0, err=0, cmd_code=0, err_type=0, raw_pattern=0, cmd_count=0, err_count=0.
- Starting in WAIT_LOW guarantees that reset released in the middle of a high frame does not lock onto a partial pattern.
- Strobes are never asserted in two consecutive cycles.

## Test plan
- Send each of the five patterns, one guard 0 between them -> cmd_valid pulses with cmd_code 0,1,2,3,4 in order, each 4 cycles after its first bit; cmd_count=5, err_count=0.
- Pattern 1001 then 0 -> err=1, err_type=1, raw_pattern=0x9, no cmd_valid; err_count=1.
- Line held high for 6 cycles, then 0, then pattern 1000 -> err_type=2 at guard, no further error while high; the following 1000 decodes to cmd_code=1.
- Assert rst during bit 2 of 1110 and release while the line is still high -> all outputs 0; remaining bits ignored; the next full frame 1100 decodes to code 2.
- Drop en during CAPTURE, raise it before the guard bit -> no strobe for that frame; the next frame decodes normally.
- Preload 65534 commands, then send 3 more, with clr_cnt asserted on the third strobe cycle -> cmd_count reads 0xFFFF, stays at 0xFFFF, then 0.

Source files
------------

// File: rtl/trig_pattern_decoder.sv
// Turns 4-bit pulse frames on the serial trigger line into command strobes,
// per-frame status and saturating command/error counters.
module trig_pattern_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        trig_in,
  input  logic        clr_cnt,
  output logic        cmd_valid,
  output logic [2:0]  cmd_code,
  output logic        err,
  output logic [1:0]  err_type,
  output logic [3:0]  raw_pattern,
  output logic [15:0] cmd_count,
  output logic [15:0] err_count
);

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    CAPTURE  = 2'd2,
    GUARD    = 2'd3
  } state_t;

  localparam logic [1:0]  ERR_UNKNOWN = 2'd1;
  localparam logic [1:0]  ERR_FRAMING = 2'd2;
  localparam logic [15:0] CNT_MAX     = 16'hFFFF;

  state_t      state;
  logic [2:0]  shift;
  logic [2:0]  bit_cnt;
  logic [3:0]  lookup;
  logic        known;
  logic [2:0]  known_code;
  logic        emit_cmd;
  logic        emit_err;

  // Result is {known, code}; anything not listed is an unknown pattern.
  function automatic logic [3:0] decode(input logic [3:0] pattern);
    logic [3:0] result;
    result = 4'b0_000;
    case (pattern)
      4'b1110: result = 4'b1_000;
      4'b1000: result = 4'b1_001;
      4'b1100: result = 4'b1_010;
      4'b1010: result = 4'b1_011;
      4'b1111: result = 4'b1_100;
      default: result = 4'b0_000;
    endcase
    return result;
  endfunction

  always_comb begin
    lookup     = decode(raw_pattern);
    known      = lookup[3];
    known_code = lookup[2:0];
    emit_cmd   = 1'b0;
    emit_err   = 1'b0;
    if (en && (state == GUARD)) begin
      emit_cmd = !trig_in && known;
      emit_err = trig_in || !known;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_LOW;
      shift       <= 3'd0;
      bit_cnt     <= 3'd0;
      raw_pattern <= 4'd0;
      cmd_valid   <= 1'b0;
      cmd_code    <= 3'd0;
      err         <= 1'b0;
      err_type    <= 2'd0;
    end else begin
      cmd_valid <= 1'b0;
      err       <= 1'b0;
      if (!en) begin
        state <= WAIT_LOW;
      end else begin
        case (state)
          WAIT_LOW: begin
            if (!trig_in) state <= IDLE;
          end
          IDLE: begin
            if (trig_in) begin
              shift   <= 3'b001;
              bit_cnt <= 3'd1;
              state   <= CAPTURE;
            end
          end
          CAPTURE: begin
            shift   <= {shift[1:0], trig_in};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd3) begin
              raw_pattern <= {shift, trig_in};
              state       <= GUARD;
            end
          end
          GUARD: begin
            // A high guard bit means the line is still busy; resync on a low.
            if (trig_in) begin
              err      <= 1'b1;
              err_type <= ERR_FRAMING;
              state    <= WAIT_LOW;
            end else begin
              if (emit_cmd) begin
                cmd_valid <= 1'b1;
                cmd_code  <= known_code;
              end else begin
                err      <= 1'b1;
                err_type <= ERR_UNKNOWN;
              end
              state <= IDLE;
            end
          end
          default: state <= WAIT_LOW;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_count <= 16'd0;
      err_count <= 16'd0;
    end else if (clr_cnt) begin
      cmd_count <= 16'd0;
      err_count <= 16'd0;
    end else begin
      if (emit_cmd && (cmd_count != CNT_MAX)) cmd_count <= cmd_count + 16'd1;
      if (emit_err && (err_count != CNT_MAX)) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_trig_pattern_decoder.sv
// Scoreboard bench for trig_pattern_decoder: directed frames push expected
// strobes into a queue, a negedge monitor pops and compares them.
module tb_trig_pattern_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        trig_in;
  logic        clr_cnt;
  logic        cmd_valid;
  logic [2:0]  cmd_code;
  logic        err;
  logic [1:0]  err_type;
  logic [3:0]  raw_pattern;
  logic [15:0] cmd_count;
  logic [15:0] err_count;

  trig_pattern_decoder dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .trig_in     (trig_in),
    .clr_cnt     (clr_cnt),
    .cmd_valid   (cmd_valid),
    .cmd_code    (cmd_code),
    .err         (err),
    .err_type    (err_type),
    .raw_pattern (raw_pattern),
    .cmd_count   (cmd_count),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_err;
    logic [2:0]  code;
    logic [1:0]  etype;
    logic [3:0]  raw;
    logic        chk_cnt;
    logic [15:0] ccnt;
    logic [15:0] ecnt;
    int          due;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_cmd = 16'd0;
  logic [15:0] exp_err = 16'd0;
  logic        prev_strobe = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic void bumpModel(input logic is_err, input logic clr);
    if (clr) begin
      exp_cmd = 16'd0;
      exp_err = 16'd0;
    end else if (is_err) begin
      if (exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
    end else begin
      if (exp_cmd != 16'hFFFF) exp_cmd = exp_cmd + 16'd1;
    end
  endfunction

  // Called at a negedge; drives 4 pattern bits and the guard bit, returns at
  // the negedge where the strobe for this frame is visible.
  task automatic applyStimulus(input logic [3:0] pat, input logic guard, input logic is_err,
                               input logic [2:0] code, input logic [1:0] etype,
                               input logic clr, input logic chk_cnt);
    exp_t e;
    bumpModel(is_err, clr);
    e.is_err  = is_err;
    e.code    = code;
    e.etype   = etype;
    e.raw     = pat;
    e.chk_cnt = chk_cnt;
    e.ccnt    = exp_cmd;
    e.ecnt    = exp_err;
    e.due     = cyc + 5;
    sb.push_back(e);
    for (int i = 0; i < 5; i++) begin
      trig_in = (i < 4) ? pat[3-i] : guard;
      clr_cnt = (i == 4) ? clr : 1'b0;
      @(negedge clk);
    end
    clr_cnt = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_cmd_valid"}, 32'(cmd_valid), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_cmd_code"}, 32'(cmd_code), 32'd0);
    checkOutput({tag, "_err_type"}, 32'(err_type), 32'd0);
    checkOutput({tag, "_raw"}, 32'(raw_pattern), 32'd0);
    checkOutput({tag, "_cmd_count"}, 32'(cmd_count), 32'd0);
    checkOutput({tag, "_err_count"}, 32'(err_count), 32'd0);
  endtask

  always @(negedge clk) begin
    if (cmd_valid || err) begin
      checkOutput("mon_strobe_gap", 32'(prev_strobe), 32'd0);
      checkOutput("mon_sb_pending", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        checkOutput("mon_latency", 32'(cyc), 32'(mon_e.due));
        checkOutput("mon_cmd_valid", 32'(cmd_valid), 32'(!mon_e.is_err));
        checkOutput("mon_err", 32'(err), 32'(mon_e.is_err));
        checkOutput("mon_raw", 32'(raw_pattern), 32'(mon_e.raw));
        if (mon_e.is_err) checkOutput("mon_err_type", 32'(err_type), 32'(mon_e.etype));
        else              checkOutput("mon_cmd_code", 32'(cmd_code), 32'(mon_e.code));
        if (mon_e.chk_cnt) begin
          checkOutput("mon_cmd_count", 32'(cmd_count), 32'(mon_e.ccnt));
          checkOutput("mon_err_count", 32'(err_count), 32'(mon_e.ecnt));
        end
      end
    end
    prev_strobe = cmd_valid || err;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    en = 1'b1;
    trig_in = 1'b0;
    clr_cnt = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] five commands back to back");
    applyStimulus(4'b1110, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b1000, 1'b0, 1'b0, 3'd1, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b1100, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b1010, 1'b0, 1'b0, 3'd3, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b1111, 1'b0, 1'b0, 3'd4, 2'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("code_hold", 32'(cmd_code), 32'd4);
    checkOutput("cmd_count_five", 32'(cmd_count), 32'd5);
    checkOutput("err_count_zero", 32'(err_count), 32'd0);

    $display("[TB] unknown pattern");
    applyStimulus(4'b1001, 1'b0, 1'b1, 3'd0, 2'd1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("err_type_hold", 32'(err_type), 32'd1);

    $display("[TB] line held high, then recovery");
    applyStimulus(4'b1111, 1'b1, 1'b1, 3'd0, 2'd2, 1'b0, 1'b1);
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
    @(negedge clk);
    applyStimulus(4'b1000, 1'b0, 1'b0, 3'd1, 2'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("framing_hold", 32'(err_type), 32'd2);

    $display("[TB] reset in the middle of a frame");
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    trig_in = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    trig_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    exp_cmd = 16'd0;
    exp_err = 16'd0;
    checkResetState("midreset");
    applyStimulus(4'b1100, 1'b0, 1'b0, 3'd2, 2'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    $display("[TB] enable dropped during capture");
    trig_in = 1'b1;
    @(negedge clk);
    trig_in = 1'b1;
    en = 1'b0;
    @(negedge clk);
    trig_in = 1'b1;
    en = 1'b1;
    @(negedge clk);
    trig_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    applyStimulus(4'b1010, 1'b0, 1'b0, 3'd3, 2'd0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checkOutput("cmd_count_en", 32'(cmd_count), 32'd2);
    en = 1'b0;
    clr_cnt = 1'b1;
    @(negedge clk);
    en = 1'b1;
    clr_cnt = 1'b0;
    checkOutput("clr_while_disabled_cmd", 32'(cmd_count), 32'd0);
    checkOutput("clr_while_disabled_err", 32'(err_count), 32'd0);
    exp_cmd = 16'd0;
    exp_err = 16'd0;
    repeat (2) @(negedge clk);

    // The counter is preloaded to 65534 by forcing it; the increment under
    // force lands in the register, and re-forcing the same value before the
    // release leaves 0xFFFF whatever the release semantics are.
    $display("[TB] counter saturation and clear");
    force dut.cmd_count = 16'hFFFE;
    exp_cmd = 16'hFFFE;
    applyStimulus(4'b1110, 1'b0, 1'b0, 3'd0, 2'd0, 1'b0, 1'b0);
    force dut.cmd_count = 16'hFFFF;
    release dut.cmd_count;
    #1;
    checkOutput("sat_first", 32'(cmd_count), 32'hFFFF);
    @(negedge clk);
    applyStimulus(4'b1000, 1'b0, 1'b0, 3'd1, 2'd0, 1'b0, 1'b1);
    applyStimulus(4'b1100, 1'b0, 1'b0, 3'd2, 2'd0, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("cnt_after_clr", 32'(cmd_count), 32'd0);

    repeat (3) @(negedge clk);
    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
